ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage; consumes the ID/EX pipeline register outputs (eOp, eAluc, eAluqb, eR1, eR2, eI, eRd, ctl).
//  Single-cycle ALU (ADD/SUB/AND/OR) plus an iterative 32-cycle unsigned multiply/divide unit.
//  Stall drives the En of the PC, IF/ID and ID/EX registers low while a MUL/DIV is in flight.
//  Results and bubble-gated control feed the EX/MEM register.
// PARAMETERS
//  WIDTH     32   datapath width
//  MD_ITERS  32   multiply/divide iterations; equals WIDTH
// PORTS
//  Clk        in   1   clock; all state updates on the rising edge
//  Clrn       in   1   reset; synchronous, active-low
//  eOp        in   6   opcode from ID/EX
//  eAluc      in   2   ALU function: 00 ADD, 01 SUB, 10 AND, 11 OR
//  eAluqb     in   1   operand B select: 0 = eR2, 1 = eI
//  eR1/eR2/eI in   32  operand A / register B / sign-extended immediate
//  eRd        in   5   destination register
//  eWreg/eWmem/eReg2reg in 1   control from ID/EX
//  Ex_res     out  32  stage result: ALU, MUL/DIV, or MFHI value
//  Zero       out  1   Ex_res == 0
//  Stall      out  1   freeze upstream; the instruction stays in ID/EX
//  xWreg/xWmem out 1   eWreg/eWmem AND NOT Stall (bubble to EX/MEM)
//  xReg2reg/xRd out 1/5   pass-through
//  xR2        out  32  store data pass-through
// BEHAVIOUR
//  - Operand B = eAluqb ? eI : eR2. ALU is combinational; arithmetic is modulo 2^32 with no overflow flag.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: when eOp is OP_MUL or OP_DIV, Stall=1 combinationally and A/B are latched; next state is RUN with cnt=31.
//    DIV with B==0 skips RUN and goes straight to DONE.
//    RUN: Stall=1; one shift-add (MUL) or restoring-subtract (DIV) step per cycle; cnt decrements.
//      RUN -> DONE on the cnt==0 cycle.
//    DONE: Stall=0; Ex_res = product[31:0] or quotient; the instruction advances this edge; next state IDLE.
//  - MUL/DIV occupancy: 1 issue + 32 RUN + 1 DONE = 34 cycles. DIV by zero: 2 cycles.
//  - DIV by zero: quotient = 32'hFFFFFFFF, remainder = A.
//  - While Stall=1: Ex_res is don't-care; xWreg = xWmem = 0.
//  - ALU ops never assert Stall. All non-MUL/DIV opcodes take the ALU path.
//  - Because ID/EX is frozen by Stall, eOp is stable through RUN; it is not re-sampled in RUN/DONE.
//  - Reset (Clrn=0 at an edge), including mid-RUN: state=IDLE, cnt=0, partial results=0, Hi=0.
//    Stall=0 in the cycle after the reset edge.
// CONFIGURATION
//  HILO_EN defined: a 32-bit Hi register loads product[63:32] or the remainder at DONE.
//    OP_MFHI returns Hi with no stall. An ALU op in the same cycle does not disturb Hi.
//  HILO_EN undefined: no Hi register; upper product and remainder are discarded; OP_MFHI yields Ex_res=0.
// STRUCTURE
//  - Package cpu_pkg: OP_MUL=6'b011100, OP_DIV=6'b011010, OP_MFHI=6'b010000,
//    ALUC_ADD/SUB/AND/OR, and the md_state_t enum {IDLE,RUN,DONE}.
//  - Sub-module md_unit: FSM, counter, shift registers, start/busy/done handshake.
//  - ex_stage top: ALU, operand mux, bubble gating.
// TESTING
//  1. ADD: eR1=5, eI=7, eAluqb=1, eAluc=00 -> Ex_res=12, Zero=0, Stall=0, xWreg=eWreg same cycle.
//  2. SUB: eR1=eR2=9, eAluqb=0, eAluc=01 -> Ex_res=0, Zero=1.
//  3. MUL: 6*7 -> Stall=1 for 33 cycles, xWreg=0 throughout; DONE cycle Ex_res=42, Stall=0; next cycle IDLE.
//     Also 32'hFFFFFFFF*2 -> Ex_res=32'hFFFFFFFE, Hi=1 (HILO_EN).
//  4. DIV: 100/7 -> Ex_res=14 at DONE; with HILO_EN, a following MFHI -> 2; without HILO_EN -> 0.
//  5. DIV by 0: A=55 -> Stall=1 for exactly 1 cycle, then Ex_res=32'hFFFFFFFF; Hi=55 (HILO_EN).
//  6. Reset mid-op: Clrn=0 on RUN cycle 10 of a MUL -> state=IDLE, Stall=0 after the edge.
//     A subsequent ADD executes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the execute stage.
// Holds datapath widths, opcodes, ALU function codes and the multiply/divide
// FSM state enum. The optional Hi register is enabled with macro HILO_EN.
package cpu_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned CNT_W    = $clog2(MD_ITERS);
  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALUC_W   = 2;
  localparam int unsigned RD_W     = 5;

  localparam logic [OP_W-1:0] OP_MUL  = 6'b011100;
  localparam logic [OP_W-1:0] OP_DIV  = 6'b011010;
  localparam logic [OP_W-1:0] OP_MFHI = 6'b010000;

  localparam logic [ALUC_W-1:0] ALUC_ADD = 2'b00;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 2'b01;
  localparam logic [ALUC_W-1:0] ALUC_AND = 2'b10;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle.
// master: the pipeline side that drives ID/EX fields and consumes results.
// slave : the execute stage.
interface ex_stage_if;
  import cpu_pkg::*;

  logic [OP_W-1:0]   eOp;
  logic [ALUC_W-1:0] eAluc;
  logic              eAluqb;
  logic [WIDTH-1:0]  eR1;
  logic [WIDTH-1:0]  eR2;
  logic [WIDTH-1:0]  eI;
  logic [RD_W-1:0]   eRd;
  logic              eWreg;
  logic              eWmem;
  logic              eReg2reg;

  logic [WIDTH-1:0]  Ex_res;
  logic              Zero;
  logic              Stall;
  logic              xWreg;
  logic              xWmem;
  logic              xReg2reg;
  logic [RD_W-1:0]   xRd;
  logic [WIDTH-1:0]  xR2;

  modport master (
    output eOp, eAluc, eAluqb, eR1, eR2, eI, eRd, eWreg, eWmem, eReg2reg,
    input  Ex_res, Zero, Stall, xWreg, xWmem, xReg2reg, xRd, xR2
  );

  modport slave (
    input  eOp, eAluc, eAluqb, eR1, eR2, eI, eRd, eWreg, eWmem, eReg2reg,
    output Ex_res, Zero, Stall, xWreg, xWmem, xReg2reg, xRd, xR2
  );

endinterface

// File: rtl/ex_stage_md_unit.sv
// Iterative unsigned multiply/divide unit (one bit per cycle).
// Ports: clk, rstN (sync active-low), start (MUL/DIV present in ID/EX),
//   isDiv, a/b operands; busy (combinational stall), done (result valid
//   this cycle), resLo (product low / quotient), resHi (product high /
//   remainder, only when HILO_EN is defined).
// hi/lo form one 64-bit shift pair shared by both operations.
module md_unit
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef HILO_EN
  output logic [WIDTH-1:0] resHi,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resLo
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [WIDTH-1:0] hi, hiNext;
  logic [WIDTH-1:0] lo, loNext;
  logic [WIDTH-1:0] opB, opBNext;
  logic             opDiv, opDivNext;

  // Shift-add step: add multiplicand when the multiplier LSB is set, shift right.
  logic [WIDTH:0] mulSum;
  assign mulSum = {1'b0, hi} + (lo[0] ? {1'b0, opB} : '0);

  // Restoring-divide step: shift left, keep the difference when it is non-negative.
  logic [WIDTH:0] divShift, divDiff;
  assign divShift = {hi, lo[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opB};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opB   <= '0;
      opDiv <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      hi    <= hiNext;
      lo    <= loNext;
      opB   <= opBNext;
      opDiv <= opDivNext;
    end
  end

  // Next-state, datapath step and handshake outputs.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    hiNext    = hi;
    loNext    = lo;
    opBNext   = opB;
    opDivNext = opDiv;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy      = 1'b1;
          opBNext   = b;
          opDivNext = isDiv;
          hiNext    = '0;
          loNext    = a;
          cntNext   = CNT_W'(MD_ITERS - 1);
          stateNext = S_RUN;
          // Divide by zero: quotient all ones, remainder = dividend, no iterations.
          if (isDiv && (b == '0)) begin
            hiNext    = a;
            loNext    = '1;
            cntNext   = '0;
            stateNext = S_DONE;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (opDiv) begin
          if (!divDiff[WIDTH]) begin
            hiNext = divDiff[WIDTH-1:0];
            loNext = {lo[WIDTH-2:0], 1'b1};
          end else begin
            hiNext = divShift[WIDTH-1:0];
            loNext = {lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          hiNext = mulSum[WIDTH:1];
          loNext = {mulSum[0], lo[WIDTH-1:1]};
        end
        cntNext = cnt - CNT_W'(1);
        if (cnt == '0) begin
          cntNext   = '0;
          stateNext = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  assign resLo = lo;
`ifdef HILO_EN
  assign resHi = hi;
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative MUL/DIV, bubble gating to EX/MEM.
// Ports: Clk, Clrn (sync active-low reset), bus (ex_stage_if.slave) carrying
//   the ID/EX fields in and Ex_res/Zero/Stall plus EX/MEM control out.
// Optional macro HILO_EN adds a Hi register readable via OP_MFHI.
module ex_stage
  import cpu_pkg::*;
(
  input  logic      Clk,
  input  logic      Clrn,
  ex_stage_if.slave bus
);

  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] mdLo;
  logic [WIDTH-1:0] mfhiVal;
  logic [WIDTH-1:0] exRes;
  logic             isMd;
  logic             mdBusy;
  logic             mdDone;

  assign opB  = bus.eAluqb ? bus.eI : bus.eR2;
  assign isMd = (bus.eOp == OP_MUL) || (bus.eOp == OP_DIV);

  // ALU, modulo 2^WIDTH.
  always_comb begin
    aluRes = '0;
    case (bus.eAluc)
      ALUC_ADD: aluRes = bus.eR1 + opB;
      ALUC_SUB: aluRes = bus.eR1 - opB;
      ALUC_AND: aluRes = bus.eR1 & opB;
      ALUC_OR:  aluRes = bus.eR1 | opB;
      default:  aluRes = '0;
    endcase
  end

`ifdef HILO_EN
  logic [WIDTH-1:0] mdHi;
  logic [WIDTH-1:0] hiReg;
`endif

  md_unit uMd (
    .clk   (Clk),
    .rstN  (Clrn),
    .start (isMd),
    .isDiv (bus.eOp == OP_DIV),
    .a     (bus.eR1),
    .b     (opB),
`ifdef HILO_EN
    .resHi (mdHi),
`endif
    .busy  (mdBusy),
    .done  (mdDone),
    .resLo (mdLo)
  );

`ifdef HILO_EN
  // Hi only changes when a MUL/DIV completes.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      hiReg <= '0;
    end else if (mdDone) begin
      hiReg <= mdHi;
    end
  end
  assign mfhiVal = hiReg;
`else
  assign mfhiVal = '0;
`endif

  // eOp is still MUL/DIV in the DONE cycle, so the completion result takes priority.
  assign exRes = mdDone                ? mdLo    :
                 (bus.eOp == OP_MFHI)  ? mfhiVal : aluRes;

  assign bus.Ex_res   = exRes;
  assign bus.Zero     = (exRes == '0);
  assign bus.Stall    = mdBusy;
  assign bus.xWreg    = bus.eWreg & ~mdBusy;
  assign bus.xWmem    = bus.eWmem & ~mdBusy;
  assign bus.xReg2reg = bus.eReg2reg;
  assign bus.xRd      = bus.eRd;
  assign bus.xR2      = bus.eR2;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors, per-cycle reference
// model (plain arithmetic, occupancy counts) and hand-computed expectations.
module tb_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .Clk  (clk),
    .Clrn (rstN),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining stall cycles of the MUL/DIV in flight (-1 = none).
  int          mdLeft = -1;
  logic [31:0] mA, mB, mHi = '0;
  bit          mDiv;

  always @(negedge clk) begin
    logic [31:0] b, expRes, newHi;
    logic [63:0] prod;
    if (!rstN) begin
      mdLeft = -1;
      mHi    = '0;
    end else begin
      b = bus.eAluqb ? bus.eI : bus.eR2;
      newHi = mHi;
      if (mdLeft < 0 && (bus.eOp == OP_MUL || bus.eOp == OP_DIV)) begin
        mA     = bus.eR1;
        mB     = b;
        mDiv   = (bus.eOp == OP_DIV);
        mdLeft = (mDiv && b == 0) ? 1 : 33;
      end
      chk("m_xRd", 32'(bus.xRd), 32'(bus.eRd));
      chk("m_xR2", bus.xR2, bus.eR2);
      chk("m_xReg2reg", 32'(bus.xReg2reg), 32'(bus.eReg2reg));
      if (mdLeft > 0) begin
        chk("m_stall_hi", 32'(bus.Stall), 32'd1);
        chk("m_xWreg_bubble", 32'(bus.xWreg), 32'd0);
        chk("m_xWmem_bubble", 32'(bus.xWmem), 32'd0);
        mdLeft--;
      end else begin
        if (mdLeft == 0) begin
          if (mDiv) begin
            if (mB == 0) begin
              expRes = 32'hFFFF_FFFF;
              newHi  = mA;
            end else begin
              expRes = mA / mB;
              newHi  = mA % mB;
            end
          end else begin
            prod   = 64'(mA) * 64'(mB);
            expRes = prod[31:0];
            newHi  = prod[63:32];
          end
        end else if (bus.eOp == OP_MFHI) begin
`ifdef HILO_EN
          expRes = mHi;
`else
          expRes = 32'd0;
`endif
        end else begin
          case (bus.eAluc)
            ALUC_ADD: expRes = bus.eR1 + b;
            ALUC_SUB: expRes = bus.eR1 - b;
            ALUC_AND: expRes = bus.eR1 & b;
            default:  expRes = bus.eR1 | b;
          endcase
        end
        chk("m_stall_lo", 32'(bus.Stall), 32'd0);
        chk("m_ex_res", bus.Ex_res, expRes);
        chk("m_zero", 32'(bus.Zero), 32'(expRes == 0));
        chk("m_xWreg", 32'(bus.xWreg), 32'(bus.eWreg));
        chk("m_xWmem", 32'(bus.xWmem), 32'(bus.eWmem));
        if (mdLeft == 0) begin
          mHi    = newHi;
          mdLeft = -1;
        end
      end
    end
  end

  task automatic setIn(input logic [5:0] op, input logic [1:0] aluc, input logic qb,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic wreg, input logic wmem);
    bus.eOp      = op;
    bus.eAluc    = aluc;
    bus.eAluqb   = qb;
    bus.eR1      = r1;
    bus.eR2      = r2;
    bus.eI       = imm;
    bus.eRd      = rd;
    bus.eWreg    = wreg;
    bus.eWmem    = wmem;
    bus.eReg2reg = rd[0];
  endtask

  task automatic drive(input logic [5:0] op, input logic [1:0] aluc, input logic qb,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic wreg, input logic wmem);
    @(posedge clk);
    #1;
    setIn(op, aluc, qb, r1, r2, imm, rd, wreg, wmem);
  endtask

  // Single-cycle instruction with hand-computed result.
  task automatic aluOp(input string name, input logic [5:0] op, input logic [1:0] aluc,
                       input logic qb, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] expRes);
    drive(op, aluc, qb, r1, r2, imm, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk({name, "_res"}, bus.Ex_res, expRes);
    chk({name, "_zero"}, 32'(bus.Zero), 32'(expRes == 0));
    chk({name, "_stall"}, 32'(bus.Stall), 32'd0);
    chk({name, "_xWreg"}, 32'(bus.xWreg), 32'd1);
  endtask

  // MUL/DIV: count stall cycles (bounded), then check the DONE-cycle result.
  task automatic mdOp(input string name, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int expStall, input logic [31:0] expRes);
    int n;
    n = 0;
    drive(op, ALUC_ADD, 1'b0, a, b, 32'd0, 5'd9, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    while (bus.Stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(expStall));
    chk({name, "_done_res"}, bus.Ex_res, expRes);
    chk({name, "_done_xWreg"}, 32'(bus.xWreg), 32'd1);
  endtask

  initial begin
    logic [31:0] hiExp;
    rstN = 1'b0;
    setIn(6'd0, ALUC_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_stall", 32'(bus.Stall), 32'd0);
    chk("reset_res", bus.Ex_res, 32'd0);
    chk("reset_zero", 32'(bus.Zero), 32'd1);

    aluOp("add_imm", 6'd0, ALUC_ADD, 1'b1, 32'd5, 32'd100, 32'd7, 32'd12);
    aluOp("sub_eq", 6'd0, ALUC_SUB, 1'b0, 32'd9, 32'd9, 32'd1, 32'd0);
    aluOp("sub_wrap", 6'd0, ALUC_SUB, 1'b0, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF);
    aluOp("and", 6'd0, ALUC_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'h00F0_1200);
    aluOp("or_imm", 6'd0, ALUC_OR, 1'b1, 32'hA000_0005, 32'd0, 32'h0000_0F00, 32'hA000_0F05);
    aluOp("add_wrap", 6'd0, ALUC_ADD, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0);

    mdOp("mul_6x7", OP_MUL, 32'd6, 32'd7, 33, 32'd42);
    aluOp("add_after_mul", 6'd0, ALUC_ADD, 1'b1, 32'd1, 32'd0, 32'd2, 32'd3);
    mdOp("mul_big", OP_MUL, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE);
`ifdef HILO_EN
    hiExp = 32'd1;
`else
    hiExp = 32'd0;
`endif
    aluOp("mfhi_mul", OP_MFHI, ALUC_ADD, 1'b0, 32'd0, 32'd0, 32'd0, hiExp);

    mdOp("div_100_7", OP_DIV, 32'd100, 32'd7, 33, 32'd14);
`ifdef HILO_EN
    hiExp = 32'd2;
`else
    hiExp = 32'd0;
`endif
    aluOp("mfhi_div", OP_MFHI, ALUC_ADD, 1'b0, 32'd0, 32'd0, 32'd0, hiExp);

    mdOp("div_zero", OP_DIV, 32'd55, 32'd0, 1, 32'hFFFF_FFFF);
`ifdef HILO_EN
    hiExp = 32'd55;
`else
    hiExp = 32'd0;
`endif
    aluOp("mfhi_dz", OP_MFHI, ALUC_ADD, 1'b0, 32'd0, 32'd0, 32'd0, hiExp);
    aluOp("add_keep_hi", 6'd0, ALUC_ADD, 1'b0, 32'd4, 32'd4, 32'd0, 32'd8);
    aluOp("mfhi_again", OP_MFHI, ALUC_ADD, 1'b0, 32'd0, 32'd0, 32'd0, hiExp);

    // Reset in RUN cycle 10 of a MUL; the following ADD must not stall.
    drive(OP_MUL, ALUC_ADD, 1'b0, 32'd6, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_run_stall", 32'(bus.Stall), 32'd1);
    rstN = 1'b0;
    setIn(6'd0, ALUC_ADD, 1'b1, 32'd5, 32'd0, 32'd7, 5'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_stall", 32'(bus.Stall), 32'd0);
    chk("post_reset_add", bus.Ex_res, 32'd12);
    chk("post_reset_xWreg", 32'(bus.xWreg), 32'd1);
    aluOp("mfhi_after_reset", OP_MFHI, ALUC_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    mdOp("mul_3x5", OP_MUL, 32'd3, 32'd5, 33, 32'd15);
    aluOp("final_or", 6'd0, ALUC_OR, 1'b0, 32'd1, 32'd2, 32'd0, 32'd3);

    drive(6'd0, ALUC_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
